// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-port 16-bit memory between fetch and data requesters
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [15:0]           i_rdata,
    output logic                  i_done,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic [15:0]           d_rdata,
    output logic                  d_done,
    output logic                  d_err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data_in,
    output logic                  mem_enable,
    output logic                  mem_wr,
    input  logic [15:0]           mem_data_out
);
    localparam int CW = $clog2(WAIT_CYCLES) + 1;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t                state_q;
    logic                  owner_q, last_q, wr_q, err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           wdata_q, rdata_q;
    logic [CW-1:0]         cnt_q;
    logic                  pick_d, last_cnt, acc, fin;
    logic [ADDR_WIDTH-1:0] addr_d;
    // owner/last_grant encoding: 0 = fetch, 1 = data; a tie goes to the side not granted last
    assign pick_d   = d_req && (!i_req || !last_q);
    assign addr_d   = pick_d ? d_addr : i_addr;
    assign last_cnt = cnt_q == CW'(WAIT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (i_req || d_req) begin
                    owner_q <= pick_d;
                    last_q  <= pick_d;
                    addr_q  <= addr_d;
                    wr_q    <= pick_d && d_wr;
                    wdata_q <= pick_d ? d_wdata : 16'h0;
                    err_q   <= addr_d[0];
                    rdata_q <= '0;
                    cnt_q   <= '0;
                    state_q <= addr_d[0] ? DONE : ACCESS;
                end
                ACCESS: if (last_cnt) begin
                    rdata_q <= wr_q ? 16'h0 : mem_data_out;
                    state_q <= DONE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign acc         = state_q == ACCESS;
    assign fin         = state_q == DONE;
    assign busy        = state_q != IDLE;
    assign i_done      = fin && !owner_q;
    assign d_done      = fin && owner_q;
    assign i_err       = i_done && err_q;
    assign d_err       = d_done && err_q;
    assign i_rdata     = i_done ? rdata_q : 16'h0;
    assign d_rdata     = d_done ? rdata_q : 16'h0;
    assign mem_enable  = acc;
    assign mem_addr    = acc ? addr_q : '0;
    assign mem_data_in = acc ? wdata_q : 16'h0;
    assign mem_wr      = acc && wr_q && last_cnt;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (WAIT_CYCLES 1 and 3) each on its own small memory, checked against a word-level model
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst [2];
    logic        i_req [2], d_req [2], d_wr [2];
    logic [15:0] i_addr [2], d_addr [2], d_wdata [2];
    logic [15:0] i_rdata [2], d_rdata [2];
    logic        i_done [2], i_err [2], d_done [2], d_err [2], busy [2];
    logic [15:0] mem_addr [2], mem_data_in [2], mem_data_out [2];
    logic        mem_enable [2], mem_wr [2];
    logic [15:0] mem [2][64] = '{default: '0};
    logic [15:0] ref_mem [2][64] = '{default: '0};
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        mem_port_arbiter #(.ADDR_WIDTH(16), .WAIT_CYCLES(g == 0 ? 1 : 3)) dut (
            .clk(clk), .rst(rst[g]),
            .i_req(i_req[g]), .i_addr(i_addr[g]), .i_rdata(i_rdata[g]), .i_done(i_done[g]), .i_err(i_err[g]),
            .d_req(d_req[g]), .d_wr(d_wr[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_rdata(d_rdata[g]), .d_done(d_done[g]), .d_err(d_err[g]), .busy(busy[g]),
            .mem_addr(mem_addr[g]), .mem_data_in(mem_data_in[g]), .mem_enable(mem_enable[g]),
            .mem_wr(mem_wr[g]), .mem_data_out(mem_data_out[g])
        );
        assign mem_data_out[g] = mem[g][mem_addr[g][6:1]];
        always @(posedge clk)
            if (!rst[g] && mem_enable[g] && mem_wr[g]) mem[g][mem_addr[g][6:1]] <= mem_data_in[g];
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic all_zero(int v, string tag);
        chk({tag, ".rdata"}, {i_rdata[v], d_rdata[v]}, 32'h0);
        chk({tag, ".memdrv"}, {mem_addr[v], mem_data_in[v]}, 32'h0);
        chk({tag, ".flags"}, 32'({i_done[v], d_done[v], i_err[v], d_err[v], busy[v], mem_enable[v], mem_wr[v]}), 32'h0);
    endtask

    // Called at a negedge while the unit is idle; returns at a negedge with the unit idle again.
    task automatic access(int v, bit port, bit wr, logic [15:0] addr, logic [15:0] wd, string tag);
        int w = (v == 0) ? 1 : 3;
        int n = 0, en = 0, wrs = 0, bad = 0, other = 0, nb = 0;
        bit mis = addr[0], got = 0, seen_err = 0;
        logic [15:0] exp_rd, seen_rd = 16'hdead;
        exp_rd = (mis || wr) ? 16'h0 : ref_mem[v][addr[6:1]];
        if (port) begin
            d_req[v] = 1; d_wr[v] = wr; d_addr[v] = addr; d_wdata[v] = wd;
        end else begin
            i_req[v] = 1; i_addr[v] = addr;
        end
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (busy[v] !== 1'b1) nb++;
            if (mem_enable[v]) begin en++; if (mem_addr[v] !== addr) bad++; end
            if (mem_wr[v]) begin wrs++; if (mem_data_in[v] !== wd) bad++; end
            if (port ? i_done[v] : d_done[v]) other++;
            if (port ? d_done[v] : i_done[v]) begin
                got = 1;
                seen_rd = port ? d_rdata[v] : i_rdata[v];
                seen_err = port ? d_err[v] : i_err[v];
            end
        end
        i_req[v] = 0; d_req[v] = 0; d_wr[v] = 0;
        if (!mis && wr) ref_mem[v][addr[6:1]] = wd;
        chk({tag, ".latency"}, 32'(n), 32'(mis ? 1 : w + 1));
        chk({tag, ".rdata"}, 32'(seen_rd), 32'(exp_rd));
        chk({tag, ".err"}, 32'(seen_err), 32'(mis));
        chk({tag, ".en_cycles"}, 32'(en), 32'(mis ? 0 : w));
        chk({tag, ".wr_cycles"}, 32'(wrs), 32'(wr && !mis));
        chk({tag, ".drive"}, 32'(bad), 32'h0);
        chk({tag, ".other_done"}, 32'(other), 32'h0);
        chk({tag, ".busy"}, 32'(nb), 32'h0);
        @(negedge clk);
        chk({tag, ".idle"}, 32'({busy[v], i_done[v], d_done[v], mem_enable[v]}), 32'h0);
    endtask

    initial begin
        int cyc, nd, both, dn, badrd, badcyc;
        bit [3:0] order;
        for (int v = 0; v < 2; v++) begin
            rst[v] = 1; i_req[v] = 0; d_req[v] = 0; d_wr[v] = 0;
            i_addr[v] = 0; d_addr[v] = 0; d_wdata[v] = 0;
        end
        repeat (2) @(negedge clk);
        all_zero(0, "reset0");
        all_zero(1, "reset1");
        rst[0] = 0; rst[1] = 0;
        @(negedge clk);

        access(0, 1, 1, 16'h0004, 16'hBEEF, "preload");
        access(0, 0, 0, 16'h0004, 16'h0000, "fetch_beef");
        access(0, 1, 1, 16'h0010, 16'h1234, "dwrite");
        access(0, 1, 0, 16'h0010, 16'h0000, "dread");

        rst[0] = 1;
        @(negedge clk);
        rst[0] = 0;
        i_req[0] = 1; i_addr[0] = 16'h0004;
        d_req[0] = 1; d_wr[0] = 0; d_addr[0] = 16'h0010;
        cyc = 0; dn = 0; both = 0; badrd = 0; badcyc = 0; order = 4'b0;
        while (dn < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (i_done[0] && d_done[0]) both++;
            if (i_done[0] || d_done[0]) begin
                order[dn] = d_done[0];
                if (cyc != 2 + 3 * dn) badcyc++;
                if (d_done[0] ? d_rdata[0] !== 16'h1234 : i_rdata[0] !== 16'hBEEF) badrd++;
                dn++;
            end
        end
        i_req[0] = 0; d_req[0] = 0;
        @(negedge clk);
        chk("tie.count", 32'(dn), 32'd4);
        chk("tie.order", 32'(order), 32'b1010);
        chk("tie.both_done", 32'(both), 32'h0);
        chk("tie.done_cycles", 32'(badcyc), 32'h0);
        chk("tie.rdata", 32'(badrd), 32'h0);
        chk("tie.idle", 32'(busy[0]), 32'h0);

        access(0, 1, 1, 16'h0003, 16'hFFFF, "mis_wr");
        chk("mis_wr.mem", 32'(mem[0][1]), 32'(ref_mem[0][1]));
        access(0, 0, 0, 16'h0007, 16'h0000, "mis_fetch");

        access(1, 1, 1, 16'h0020, 16'hCAFE, "u1_wr");
        nd = 0;
        d_req[1] = 1; d_wr[1] = 1; d_addr[1] = 16'h0020; d_wdata[1] = 16'h5555;
        @(negedge clk);
        if (d_done[1]) nd++;
        chk("rstmid.acc1", 32'({busy[1], mem_enable[1], mem_wr[1]}), 32'b110);
        @(negedge clk);
        if (d_done[1]) nd++;
        rst[1] = 1; d_req[1] = 0;
        @(negedge clk);
        if (d_done[1]) nd++;
        all_zero(1, "rstmid.after");
        rst[1] = 0;
        chk("rstmid.no_done", 32'(nd), 32'h0);
        chk("rstmid.mem", 32'(mem[1][16]), 32'hCAFE);
        @(negedge clk);
        access(1, 1, 0, 16'h0020, 16'h0000, "rstmid.read");

        for (int v = 0; v < 2; v++)
            for (int k = 0; k < 30; k++) begin
                bit p, wr;
                logic [15:0] a;
                p = 1'($urandom % 2);
                wr = p && 1'($urandom % 2);
                a = 16'($urandom_range(0, 127));
                if ($urandom % 5 != 0) a[0] = 1'b0;
                access(v, p, wr, a, 16'($urandom), $sformatf("rand%0d_%0d", v, k));
            end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single-port 16-bit byte-addressable memory between an instruction-fetch requester (read-only) and a data requester (read/write). Round-robin arbitration, a fixed number of access wait cycles, and serialised accesses ensure the memory never sees concurrent read and write. Sits between fetch/load-store logic and the memory instance, driving its `addr`, `data_in`, `enable` and `wr` inputs.

## Interface
- `ADDR_WIDTH`, 16, address width, matching the memory.
- `WAIT_CYCLES`, 1, number of cycles the memory is driven per access; must be ≥1.
- `clk` in 1 — single clock; all state changes on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `i_req` in 1 — fetch request.
- `i_addr` in ADDR_WIDTH — fetch byte address.
- `i_rdata` out 16 — fetch read data; valid while `i_done`=1.
- `i_done` out 1 — one-cycle completion pulse for fetch.
- `i_err` out 1 — misaligned fetch; pulses with `i_done`.
- `d_req` in 1 — data request.
- `d_wr` in 1 — 1 = write, 0 = read.
- `d_addr` in ADDR_WIDTH — data byte address.
- `d_wdata` in 16 — write data.
- `d_rdata` out 16 — data read result; valid while `d_done`=1.
- `d_done` out 1 — one-cycle completion pulse for data.
- `d_err` out 1 — misaligned data access; pulses with `d_done`.
- `busy` out 1 — high in any state other than IDLE.
- `mem_addr` out ADDR_WIDTH — to memory `addr`.
- `mem_data_in` out 16 — to memory `data_in`.
- `mem_enable` out 1 — to memory `enable`.
- `mem_wr` out 1 — to memory `wr`.
- `mem_data_out` in 16 — from memory `data_out`; combinational read.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: arbitrate when `i_req` or `d_req` is high.
  - Only one requesting: grant it.
  - Both requesting: grant the one not in `last_grant`.
  - `last_grant` resets to DATA, so fetch wins the first tie.
- On grant, latch the following. Requesters need not hold inputs after the grant edge, but keep `req` high until `done`.
  - Owner.
  - Address.
  - `wr`: forced 0 for fetch.
  - Write data.
  - Also update `last_grant`.
- Misaligned grant (latched addr[0]=1): go directly IDLE→DONE with err=1 and rdata=0. The memory is never enabled.
- ACCESS: a wait counter runs 0..WAIT_CYCLES-1.
  - Memory drive: `mem_addr`=latched addr and `mem_enable`=1 throughout.
  - `mem_data_in`=latched wdata.
  - `mem_wr`=1 only on the final count, and only for writes. Reads keep `mem_wr`=0 throughout.
  - On the final count: a read captures `mem_data_out` into the owner's rdata register, then go to DONE.
- DONE: owner's `done` is high for exactly one cycle, then IDLE. The non-owner's `done`/`err` stay 0.
- A `req` still high in the DONE cycle is not sampled. It is arbitrated in the following IDLE cycle as a new request.
- `mem_enable`, `mem_wr` and `mem_addr` are decoded from registered state only: no combinational path from `*_req` to memory.
  - Outside ACCESS all `mem_*` outputs are 0.
- Writes return `*_rdata`=0.

## Timing
- Request sampled in IDLE at edge k:
  - ACCESS during cycles k+1 .. k+WAIT_CYCLES.
  - Write strobe in cycle k+WAIT_CYCLES.
  - `done` in cycle k+WAIT_CYCLES+1.
  - IDLE again at k+WAIT_CYCLES+2.
- Misaligned: `done`+`err` in cycle k+1.
- Throughput: one access per WAIT_CYCLES+2 cycles. With both requesters continuously asserting, grants alternate I, D, I, D…
- Reset values: state=IDLE, counter=0, `last_grant`=DATA. All outputs are 0: both rdata, both done, both err, `busy` and all `mem_*`.
- Reset mid-ACCESS: state returns to IDLE at the reset edge. No `done` is issued and the access is abandoned.
  - The memory ignores writes while `rst`=1, so no partial write results.
  - The requester re-issues after reset.
- Counter width: $clog2(WAIT_CYCLES)+1 bits; it never wraps within an access.

## Test plan
- Reset, then `i_req`=1 with `i_addr`=0x0004 and the word at mem[2]=0xBEEF, WAIT_CYCLES=1:
  - `i_done` is asserted at k+2 with `i_rdata`=0xBEEF.
  - `mem_wr` stays 0 throughout.
  - `busy` is high for cycles k+1..k+2.
- Data write `d_addr`=0x0010, `d_wdata`=0x1234, then data read of 0x0010:
  - `mem_wr` is high for exactly one cycle.
  - The read returns `d_rdata`=0x1234 and `d_done` pulses each time.
- `i_req` and `d_req` asserted together and held for 4 accesses:
  - Grant order is I, D, I, D.
  - Each `done` is a single-cycle pulse and never both in the same cycle.
- `d_addr`=0x0003 with `d_wr`=1:
  - `d_done`=`d_err`=1 at k+1.
  - `mem_enable` is never asserted and memory contents are unchanged.
- WAIT_CYCLES=3 write with `rst` asserted during the second ACCESS cycle:
  - No `d_done`.
  - All outputs are 0 next cycle.
  - The target word is unchanged; a subsequent read returns the original value.
